// File: rtl/assoc_cache.sv
// N-way set-associative write-through cache with round-robin replacement.
// Define ASSOC_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module assoc_cache #(
    parameter int LOG_NUM_SETS   = 2,
    parameter int LOG_NUM_WAYS   = 1,
    parameter int LOG_NUM_BLOCKS = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int NUM_SETS   = 1 << LOG_NUM_SETS;
    localparam int NUM_WAYS   = 1 << LOG_NUM_WAYS;
    localparam int NUM_BLOCKS = 1 << LOG_NUM_BLOCKS;
    localparam int TAG_W      = ADDR_WIDTH - LOG_NUM_SETS - LOG_NUM_BLOCKS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      write_q;
    logic                      hit_q;
    logic [LOG_NUM_WAYS-1:0]   way_q;
    logic                      evict_q;
    logic [LOG_NUM_BLOCKS-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]     rdata_q;

    logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
    logic [LOG_NUM_WAYS-1:0]   rr_q    [NUM_SETS];
    logic [TAG_W-1:0]          tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]     data_q  [NUM_SETS][NUM_WAYS][NUM_BLOCKS];

    logic [TAG_W-1:0]          tag_s;
    logic [LOG_NUM_SETS-1:0]   set_s;
    logic [LOG_NUM_BLOCKS-1:0] off_s;

    assign tag_s = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign set_s = addr_q[LOG_NUM_BLOCKS +: LOG_NUM_SETS];
    assign off_s = addr_q[LOG_NUM_BLOCKS-1:0];

    logic                    hit;
    logic [LOG_NUM_WAYS-1:0] hit_way;
    logic                    inv_found;
    logic [LOG_NUM_WAYS-1:0] victim;
    logic                    cnt_last;

    assign cnt_last = (cnt_q == LOG_NUM_BLOCKS'(NUM_BLOCKS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[set_s][w] && tag_q[set_s][w] == tag_s) begin
                hit     = 1'b1;
                hit_way = LOG_NUM_WAYS'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        inv_found = 1'b0;
        victim    = rr_q[set_s];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_s][w]) begin
                inv_found = 1'b1;
                victim    = LOG_NUM_WAYS'(w);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_hit      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (write_q)  state_d = WRITE;
                else if (hit) state_d = RESP;
                else          state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_s, set_s, cnt_q};
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) state_d = cnt_last ? RESP : FILL_REQ;
            end
            WRITE: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
                if (mem_req_ready) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_hit   = hit_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            evict_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                    end
                end
                LOOKUP: begin
                    hit_q   <= hit;
                    rdata_q <= '0;
                    if (!write_q && hit) begin
                        rdata_q <= data_q[set_s][hit_way][off_s];
                    end
                    if (!write_q && !hit) begin
                        way_q                  <= victim;
                        evict_q                <= !inv_found;
                        valid_q[set_s][victim] <= 1'b0;
                        cnt_q                  <= '0;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        if (cnt_q == off_s) rdata_q <= mem_resp_rdata;
                        if (cnt_last) begin
                            valid_q[set_s][way_q] <= 1'b1;
                            if (evict_q) rr_q[set_s] <= rr_q[set_s] + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && state_q == LOOKUP) begin
            if (!write_q && !hit) tag_q[set_s][victim] <= tag_s;
            if (write_q && hit) data_q[set_s][hit_way][off_s] <= wdata_q;
        end
        if (!rst && state_q == FILL_WAIT && mem_resp_valid) begin
            data_q[set_s][way_q][cnt_q] <= mem_resp_rdata;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == RESP) begin
            if (hit_q) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with a one-cycle-latency memory model.
module tb_assoc_cache;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [7:0]  mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
`ifdef ASSOC_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    assoc_cache dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
`ifdef ASSOC_CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          rd_cnt;
    int          wr_cnt;
    logic [7:0]  rd_log [$];
    logic [7:0]  last_wa;
    logic [31:0] last_wd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) + 32'h100;
        rd_cnt         = 0;
        wr_cnt         = 0;
        last_wa        = '0;
        last_wd        = '0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    end

    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_write) begin
                mem[mem_req_addr] <= mem_req_wdata;
                wr_cnt            <= wr_cnt + 1;
                last_wa           <= mem_req_addr;
                last_wd           <= mem_req_wdata;
            end else begin
                mem_resp_valid <= 1'b1;
                mem_resp_rdata <= mem[mem_req_addr];
                rd_cnt         <= rd_cnt + 1;
                rd_log.push_back(mem_req_addr);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_req(input logic wr, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic hit, output int lat,
                          output int nrd, output int nwr);
        int rd0, wr0, n;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
        rd  = resp_rdata;
        hit = resp_hit;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic load_chk(input string tag, input logic [7:0] a,
                            input logic [31:0] exp_d, input logic exp_h);
        logic [31:0] rd;
        logic        h;
        int          lat, nrd, nwr;
        do_req(1'b0, a, 32'd0, rd, h, lat, nrd, nwr);
        check({tag, "_rdata"}, rd, exp_d);
        check({tag, "_hit"}, 32'(h), 32'(exp_h));
        check({tag, "_nrd"}, 32'(nrd), exp_h ? 32'd0 : 32'd2);
    endtask

    logic [31:0] rd;
    logic        h;
    int          lat, nrd, nwr, n, bad;

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_hit", 32'(resp_hit), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_req_addr", 32'(mem_req_addr), 32'd0);
        check("rst_mem_req_wdata", mem_req_wdata, 32'd0);
        rst = 1'b0;

        // Cold load: line 0x14/0x15 filled in order.
        do_req(1'b0, 8'h14, 32'd0, rd, h, lat, nrd, nwr);
        check("cold_rdata", rd, 32'h114);
        check("cold_hit", 32'(h), 32'd0);
        check("cold_nrd", 32'(nrd), 32'd2);
        check("cold_rd0", 32'(rd_log[0]), 32'h14);
        check("cold_rd1", 32'(rd_log[1]), 32'h15);

        do_req(1'b0, 8'h15, 32'd0, rd, h, lat, nrd, nwr);
        check("hit_rdata", rd, 32'h115);
        check("hit_hit", 32'(h), 32'd1);
        check("hit_lat", 32'(lat), 32'd2);
        check("hit_nrd", 32'(nrd), 32'd0);

        do_req(1'b1, 8'h14, 32'hDEAD, rd, h, lat, nrd, nwr);
        check("st_hit", 32'(h), 32'd1);
        check("st_rdata", rd, 32'd0);
        check("st_nwr", 32'(nwr), 32'd1);
        check("st_wa", 32'(last_wa), 32'h14);
        check("st_wd", last_wd, 32'hDEAD);
        load_chk("ld_after_st", 8'h14, 32'hDEAD, 1'b1);

        // Store miss must not allocate.
        do_req(1'b1, 8'h40, 32'hBEEF, rd, h, lat, nrd, nwr);
        check("stm_hit", 32'(h), 32'd0);
        check("stm_nwr", 32'(nwr), 32'd1);
        check("stm_wa", 32'(last_wa), 32'h40);
        load_chk("ld_40", 8'h40, 32'hBEEF, 1'b0);

        // Set 2 replacement: way0=0x14, way1=0x34, then round robin.
        load_chk("rep_14", 8'h14, 32'hDEAD, 1'b1);
        load_chk("rep_34", 8'h34, 32'h134, 1'b0);
        load_chk("rep_54", 8'h54, 32'h154, 1'b0);
        load_chk("rep_34b", 8'h34, 32'h134, 1'b1);
        load_chk("rep_14b", 8'h14, 32'hDEAD, 1'b0);
        load_chk("rep_54b", 8'h54, 32'h154, 1'b1);
        load_chk("rep_35", 8'h35, 32'h135, 1'b0);

        // Stall the fill, then reset while waiting for data.
        mem_req_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h94;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_reqv", 32'(mem_req_valid), 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req_addr != 8'h94 || !mem_req_valid || resp_valid) bad++;
        end
        check("stall_stable", 32'(bad), 32'd0);
        check("stall_addr", 32'(mem_req_addr), 32'h94);
        mem_req_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || mem_req_valid) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        load_chk("post_rst_14", 8'h14, 32'hDEAD, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
